// File: rtl/mano_mem_arb.sv
// Two-port memory arbiter for the MANO single-port main memory: CPU-first fixed
// priority with a starvation guard for I/O, fixed-latency access per grant.
module mano_mem_arb #(
    parameter int AW         = 12,
    parameter int DW         = 16,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic          mclk,
    input  logic          mrst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          io_req,
    input  logic          io_we,
    input  logic [AW-1:0] io_addr,
    input  logic [DW-1:0] io_wdata,
    output logic          io_ack,
    output logic [DW-1:0] io_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    localparam logic [3:0] LAT_LOAD   = 4'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t        state_q, state_d;
    logic [3:0]    lat_q, lat_d;
    logic [3:0]    starve_q, starve_d;
    logic          owner_q, owner_d;
    logic          busy_q, busy_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] io_rdata_q, io_rdata_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          io_ack_q, io_ack_d;
    logic          pick_io;

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        starve_d    = starve_q;
        owner_d     = owner_q;
        busy_d      = busy_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        io_rdata_d  = io_rdata_q;
        cpu_ack_d   = 1'b0;
        io_ack_d    = 1'b0;
        pick_io     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cpu_req || io_req) begin
                    // I/O wins when alone, or when the CPU has starved it long enough
                    pick_io     = io_req && (!cpu_req || (starve_q == STARVE_LIM));
                    owner_d     = pick_io;
                    mem_we_d    = pick_io ? io_we    : cpu_we;
                    mem_addr_d  = pick_io ? io_addr  : cpu_addr;
                    mem_wdata_d = pick_io ? io_wdata : cpu_wdata;
                    mem_en_d    = 1'b1;
                    busy_d      = 1'b1;
                    lat_d       = LAT_LOAD;
                    starve_d    = (!pick_io && io_req) ? starve_q + 4'd1 : 4'd0;
                    state_d     = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (lat_q == 4'd0) begin
                    if (!mem_we_q) begin
                        if (owner_q) io_rdata_d  = mem_rdata;
                        else         cpu_rdata_d = mem_rdata;
                    end
                    mem_en_d  = 1'b0;
                    mem_we_d  = 1'b0;
                    cpu_ack_d = !owner_q;
                    io_ack_d  = owner_q;
                    state_d   = S_RESP;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            S_RESP: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (mrst) begin
            state_q     <= S_IDLE;
            lat_q       <= 4'd0;
            starve_q    <= 4'd0;
            owner_q     <= 1'b0;
            busy_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            io_rdata_q  <= '0;
            cpu_ack_q   <= 1'b0;
            io_ack_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            starve_q    <= starve_d;
            owner_q     <= owner_d;
            busy_q      <= busy_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            io_rdata_q  <= io_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            io_ack_q    <= io_ack_d;
        end
    end

    assign cpu_ack   = cpu_ack_q;
    assign io_ack    = io_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign io_rdata  = io_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_mano_mem_arb.sv
// Directed bench for mano_mem_arb: a MEM_LAT=2 instance with a small memory model,
// plus a MEM_LAT=1 instance for the latency parameter.
module tb_mano_mem_arb;

    logic        mclk = 1'b0;
    logic        mrst;
    logic        cpu_req, cpu_we, io_req, io_we;
    logic [11:0] cpu_addr, io_addr;
    logic [15:0] cpu_wdata, io_wdata;
    logic        cpu_ack, io_ack, mem_en, mem_we, busy, owner;
    logic [15:0] cpu_rdata, io_rdata, mem_wdata, mem_rdata;
    logic [11:0] mem_addr;

    logic        c1_req;
    logic [11:0] c1_addr;
    logic        z1;
    logic [11:0] z12;
    logic [15:0] z16;
    logic        c1_ack, i1_ack, m1_en, m1_we, busy1, owner1;
    logic [15:0] c1_rdata, i1_rdata, m1_wdata, m1_rdata;
    logic [11:0] m1_addr;

    logic [15:0] mem [0:4095];
    int          checks = 0;
    int          errors = 0;
    logic [9:0]  exp_own;

    always #5 mclk = ~mclk;

    always @(posedge mclk) begin
        if (mrst) mem[12'h123] <= 16'hBEEF;
        else if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];
    assign m1_rdata  = mem[m1_addr];

    mano_mem_arb #(.AW(12), .DW(16), .MEM_LAT(2), .STARVE_MAX(4)) u_dut (
        .mclk(mclk), .mrst(mrst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_ack(io_ack), .io_rdata(io_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    mano_mem_arb #(.AW(12), .DW(16), .MEM_LAT(1), .STARVE_MAX(4)) u_dut_lat1 (
        .mclk(mclk), .mrst(mrst),
        .cpu_req(c1_req), .cpu_we(z1), .cpu_addr(c1_addr), .cpu_wdata(z16),
        .cpu_ack(c1_ack), .cpu_rdata(c1_rdata),
        .io_req(z1), .io_we(z1), .io_addr(z12), .io_wdata(z16),
        .io_ack(i1_ack), .io_rdata(i1_rdata),
        .mem_en(m1_en), .mem_we(m1_we), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
        .mem_rdata(m1_rdata), .busy(busy1), .owner(owner1)
    );

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        mrst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        io_req = 0; io_we = 0; io_addr = '0; io_wdata = '0;
        c1_req = 0; c1_addr = '0; z1 = 0; z12 = '0; z16 = '0;
        tick(); tick();
        check("rst_mem_en", mem_en, 0);
        check("rst_busy", busy, 0);
        check("rst_acks", {cpu_ack, io_ack}, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        mrst = 1'b0;
        tick();

        // single CPU read
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'h123;
        tick();
        cpu_addr = 12'h555;
        check("rd_c1_mem_en", mem_en, 1);
        check("rd_c1_mem_addr", mem_addr, 12'h123);
        check("rd_c1_owner", owner, 0);
        check("rd_c1_busy", busy, 1);
        tick();
        check("rd_c2_mem_en", mem_en, 1);
        check("rd_c2_mem_addr", mem_addr, 12'h123);
        check("rd_c2_ack", cpu_ack, 0);
        tick();
        check("rd_c3_mem_en", mem_en, 0);
        check("rd_c3_cpu_ack", cpu_ack, 1);
        check("rd_c3_rdata", cpu_rdata, 16'hBEEF);
        check("rd_c3_io_ack", io_ack, 0);
        cpu_req = 0;
        tick();
        check("rd_c4_ack", cpu_ack, 0);
        check("rd_c4_busy", busy, 0);
        check("rd_c4_rdata_held", cpu_rdata, 16'hBEEF);

        // single I/O write
        io_req = 1; io_we = 1; io_addr = 12'h010; io_wdata = 16'h00FF;
        tick();
        check("wr_c1_mem_we", {mem_en, mem_we}, 2'b11);
        check("wr_c1_owner", owner, 1);
        check("wr_c1_wdata", mem_wdata, 16'h00FF);
        tick();
        check("wr_c2_mem_we", {mem_en, mem_we}, 2'b11);
        tick();
        check("wr_c3_io_ack", io_ack, 1);
        check("wr_c3_cpu_ack", cpu_ack, 0);
        check("wr_c3_io_rdata", io_rdata, 0);
        io_req = 0; io_we = 0;
        tick();

        // CPU reads back the I/O write
        cpu_req = 1; cpu_addr = 12'h010;
        tick(); tick(); tick();
        check("rb_ack", cpu_ack, 1);
        check("rb_rdata", cpu_rdata, 16'h00FF);
        cpu_req = 0;
        tick();

        // simultaneous requests: CPU x4, I/O, CPU x4, I/O
        exp_own = 10'b10000_10000;
        cpu_req = 1; cpu_addr = 12'h123;
        io_req = 1; io_addr = 12'h010;
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("arb_owner_%0d", k), owner, exp_own[k]);
            tick(); tick();
            check($sformatf("arb_acks_%0d", k), {cpu_ack, io_ack},
                  exp_own[k] ? 2'b01 : 2'b10);
            tick();
        end
        check("arb_io_rdata", io_rdata, 16'h00FF);
        cpu_req = 0; io_req = 0;
        tick();

        // back-to-back CPU requests
        cpu_req = 1; cpu_addr = 12'h010;
        tick(); tick(); tick();
        check("b2b_ack1", cpu_ack, 1);
        cpu_req = 0;
        tick();
        cpu_req = 1; cpu_addr = 12'h123;
        check("b2b_c4_idle", busy, 0);
        tick();
        check("b2b_c5_mem", {mem_en, mem_addr}, {1'b1, 12'h123});
        tick();
        check("b2b_c6_ack", cpu_ack, 0);
        tick();
        check("b2b_c7_ack", cpu_ack, 1);
        check("b2b_c7_rdata", cpu_rdata, 16'hBEEF);
        cpu_req = 0;
        tick();

        // reset mid-access, request kept high
        cpu_addr = 12'h010;
        tick();
        cpu_req = 1;
        tick();
        check("rm_c1_mem_en", mem_en, 1);
        mrst = 1;
        tick();
        mrst = 0;
        check("rm_mem_en", mem_en, 0);
        check("rm_busy", busy, 0);
        check("rm_ack", cpu_ack, 0);
        check("rm_rdata", cpu_rdata, 0);
        tick();
        check("rm_c3_ack", cpu_ack, 0);
        tick();
        check("rm_c4_ack", cpu_ack, 0);
        tick();
        check("rm_c5_ack", cpu_ack, 1);
        check("rm_c5_rdata", cpu_rdata, 16'h00FF);
        cpu_req = 0;
        tick();

        // MEM_LAT = 1 instance
        c1_req = 1; c1_addr = 12'h123;
        tick();
        check("l1_c1_mem_en", m1_en, 1);
        check("l1_c1_ack", c1_ack, 0);
        tick();
        check("l1_c2_mem_en", m1_en, 0);
        check("l1_c2_ack", c1_ack, 1);
        check("l1_c2_rdata", c1_rdata, 16'hBEEF);
        c1_req = 0;
        tick();
        check("l1_c3_ack", c1_ack, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
